// File: rtl/pht_update_scheduler_pkg.sv
// Shared types and helpers for the PHT update scheduler: FSM states,
// the counter reset value and the 2-bit saturating counter update.
package pht_update_scheduler_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } pht_state_t;

  // Weakly-not-taken: the value every counter holds after a sweep.
  localparam logic [1:0] PHT_INIT = 2'b01;

  // Taken moves the counter toward 11, not-taken toward 00; both ends saturate.
  function automatic logic [1:0] sat2_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nextCtr;
    nextCtr = ctr;
    if (taken) begin
      if (ctr != 2'b11) nextCtr = ctr + 2'd1;
    end else begin
      if (ctr != 2'b00) nextCtr = ctr - 2'd1;
    end
    return nextCtr;
  endfunction

endpackage

// File: rtl/pht_update_fifo.sv
// Small circular FIFO that buffers resolved-branch updates until the table
// has a free read-modify-write slot. Depth must be a power of two so the
// pointers wrap for free.
module pht_update_fifo #(
  parameter int  DEPTH  = 4,
  parameter type T_DATA = logic
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  i_push,
  input  logic  i_pop,
  input  logic  i_flush,
  input  T_DATA i_data,
  output T_DATA o_data,
  output logic  o_full,
  output logic  o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  T_DATA              r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wrPtr;
  logic [PTR_W-1:0]   r_rdPtr;
  logic [CNT_W-1:0]   r_count;

  // Pointer and occupancy bookkeeping; flush behaves exactly like reset.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (i_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset; only slots behind the write pointer are read.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush && !reset) r_mem[r_wrPtr] <= i_data;
  end

  assign o_data  = r_mem[r_rdPtr];
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/pht_update_scheduler.sv
// Pattern history table of 2-bit counters with a same-cycle lookup port,
// an update FIFO drained at one read-modify-write per cycle, and a sweep
// FSM that rewrites every counter to weakly-not-taken after reset or on
// request.
module pht_update_scheduler
  import pht_update_scheduler_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] lookup_pc,
  output logic        pred_taken,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  output logic        upd_ready,
  input  logic        clear_req,
  output logic        busy
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  typedef struct packed {
    logic [INDEX_BITS-1:0] idx;
    logic                  taken;
  } pht_upd_t;

  pht_state_t            r_state;
  pht_state_t            w_stateNext;
  logic [INDEX_BITS-1:0] r_sweepIdx;
  logic [INDEX_BITS-1:0] w_sweepIdxNext;
  logic [1:0]            r_table [ENTRIES];

  pht_upd_t              w_pushData;
  pht_upd_t              w_head;
  logic                  w_fifoFull;
  logic                  w_fifoEmpty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_flush;
  logic [INDEX_BITS-1:0] w_lookupIdx;
  logic                  w_unusedPcBits;

  assign w_lookupIdx      = lookup_pc[INDEX_BITS+1:2];
  assign w_pushData.idx   = upd_pc[INDEX_BITS+1:2];
  assign w_pushData.taken = upd_taken;

  // Instruction-alignment bits and bits above the index never select an entry.
  assign w_unusedPcBits = ^{lookup_pc[31:INDEX_BITS+2], lookup_pc[1:0],
                            upd_pc[31:INDEX_BITS+2], upd_pc[1:0]};

  pht_update_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .T_DATA (pht_upd_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (w_pushData),
    .o_data  (w_head),
    .o_full  (w_fifoFull),
    .o_empty (w_fifoEmpty)
  );

  // FSM state and sweep position; reset always restarts the sweep at entry 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= CLEAR;
      r_sweepIdx <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_sweepIdx <= w_sweepIdxNext;
    end
  end

  // Next-state logic and outputs; clear_req is only honoured while running.
  always_comb begin
    w_stateNext    = r_state;
    w_sweepIdxNext = r_sweepIdx;
    busy           = 1'b0;
    upd_ready      = 1'b0;
    pred_taken     = 1'b0;
    w_push         = 1'b0;
    w_pop          = 1'b0;
    w_flush        = 1'b0;
    case (r_state)
      CLEAR: begin
        busy           = 1'b1;
        w_sweepIdxNext = r_sweepIdx + INDEX_BITS'(1);
        if (r_sweepIdx == '1) w_stateNext = RUN;
      end
      RUN: begin
        upd_ready  = !w_fifoFull;
        pred_taken = r_table[w_lookupIdx][1];
        if (clear_req) begin
          w_stateNext    = CLEAR;
          w_sweepIdxNext = '0;
          w_flush        = 1'b1;
        end else begin
          w_push = upd_valid && !w_fifoFull;
          w_pop  = !w_fifoEmpty;
        end
      end
      default: begin
        w_stateNext = CLEAR;
      end
    endcase
  end

  // Table writes: the sweep owns the port while clearing, otherwise the FIFO head is retired.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == CLEAR) begin
        r_table[r_sweepIdx] <= PHT_INIT;
      end else if (w_pop) begin
        r_table[w_head.idx] <= sat2_next(r_table[w_head.idx], w_head.taken);
      end
    end
  end

endmodule

// File: tb/tb_pht_update_scheduler.sv
// Scoreboard bench for pht_update_scheduler: the driver predicts each cycle's
// busy/upd_ready/pred_taken from a behavioural table-and-queue model and
// queues it; an independent monitor compares the DUT against the queue.
module tb_pht_update_scheduler;

  localparam int IB      = 6;
  localparam int ENTRIES = 64;
  localparam int DEPTH   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_ready;
  logic        clear_req;
  logic        busy;

  typedef struct {
    int idx;
    bit taken;
  } upd_s;

  typedef struct {
    bit    busy;
    bit    ready;
    bit    pred;
    string tag;
  } exp_s;

  upd_s pend[$];
  exp_s expQ[$];
  int   ctr [ENTRIES];
  int   clearLeft;
  int   sweepPos;
  bit   modelKnown;
  int   checks;
  int   errors;

  always #5 clk = ~clk;

  pht_update_scheduler #(
    .INDEX_BITS (IB),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .lookup_pc  (lookup_pc),
    .pred_taken (pred_taken),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_ready  (upd_ready),
    .clear_req  (clear_req),
    .busy       (busy)
  );

  function automatic int pcIdx(input logic [31:0] pc);
    return int'(pc[IB+1:2]);
  endfunction

  // One clock of stimulus: drive inputs, queue the expected outputs, advance the model past the edge.
  task automatic applyStimulus(input bit rst, input bit clr, input bit vld,
                               input logic [31:0] upc, input bit tk,
                               input logic [31:0] lpc, input string tag);
    exp_s e;
    upd_s u;
    bit   expReady;
    @(negedge clk);
    reset     = rst;
    clear_req = clr;
    upd_valid = vld;
    upd_pc    = upc;
    upd_taken = tk;
    lookup_pc = lpc;
    expReady  = modelKnown && (clearLeft == 0) && (pend.size() < DEPTH);
    if (modelKnown) begin
      if (clearLeft > 0) begin
        e.busy = 1'b1; e.ready = 1'b0; e.pred = 1'b0;
      end else begin
        e.busy  = 1'b0;
        e.ready = expReady;
        e.pred  = (ctr[pcIdx(lpc)] >= 2);
      end
      e.tag = tag;
      expQ.push_back(e);
    end
    if (rst) begin
      clearLeft  = ENTRIES;
      sweepPos   = 0;
      pend.delete();
      modelKnown = 1'b1;
    end else if (!modelKnown) begin
      // nothing is known about the DUT until it has seen reset
    end else if (clearLeft > 0) begin
      ctr[sweepPos] = 1;
      sweepPos++;
      clearLeft--;
    end else if (clr) begin
      clearLeft = ENTRIES;
      sweepPos  = 0;
      pend.delete();
    end else begin
      if (pend.size() > 0) begin
        u = pend.pop_front();
        if (u.taken) ctr[u.idx] = (ctr[u.idx] >= 3) ? 3 : ctr[u.idx] + 1;
        else         ctr[u.idx] = (ctr[u.idx] <= 0) ? 0 : ctr[u.idx] - 1;
      end
      if (vld && expReady) begin
        u.idx   = pcIdx(upc);
        u.taken = tk;
        pend.push_back(u);
      end
    end
  endtask

  task automatic idle(input int n, input logic [31:0] lpc, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 32'h0, 0, lpc, tag);
  endtask

  task automatic scanAll(input string tag);
    for (int i = 0; i < ENTRIES; i++) applyStimulus(0, 0, 0, 32'h0, 0, 32'(i) << 2, tag);
  endtask

  task automatic checkOutput(input exp_s e);
    checks++;
    if ({busy, upd_ready, pred_taken} !== {e.busy, e.ready, e.pred}) begin
      errors++;
      $display("[TB] FAIL %s at %0t: busy/ready/pred got %b%b%b expected %b%b%b",
               e.tag, $time, busy, upd_ready, pred_taken, e.busy, e.ready, e.pred);
    end
  endtask

  // Monitor: compares one queued expectation per cycle, well after the drive point.
  initial begin
    exp_s e;
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  // Safety net so the run can never hang.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] upc;
    logic [31:0] lpc;
    int          pick;
    checks = 0; errors = 0; modelKnown = 1'b0; clearLeft = 0; sweepPos = 0;
    for (int i = 0; i < ENTRIES; i++) ctr[i] = 1;
    reset = 1'b1; clear_req = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; lookup_pc = '0;

    // Reset, full sweep, then every index must predict not-taken.
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 32'h0, 0, 32'h10, "reset");
    for (int i = 0; i < ENTRIES; i++) applyStimulus(0, 0, 1, 32'h10, 1, 32'(i) << 2, "sweep");
    scanAll("post_sweep");

    // Single taken update and its neighbour.
    applyStimulus(0, 0, 1, 32'h0000_0010, 1, 32'h10, "single_issue");
    idle(3, 32'h10, "single_hit");
    idle(2, 32'h14, "single_neighbour");

    // Saturation sequence on 0x20.
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 32'h20, 1, 32'h20, "sat_taken");
    idle(2, 32'h20, "sat_top");
    applyStimulus(0, 0, 1, 32'h20, 0, 32'h20, "sat_nt1");
    idle(2, 32'h20, "sat_weak_t");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 32'h20, 0, 32'h20, "sat_nt3");
    idle(2, 32'h20, "sat_bottom");
    applyStimulus(0, 0, 1, 32'h20, 0, 32'h20, "sat_nt_extra");
    idle(1, 32'h20, "sat_floor");
    applyStimulus(0, 0, 1, 32'h20, 1, 32'h20, "sat_floor_probe");
    idle(2, 32'h20, "sat_floor_check");

    // Back-to-back distinct updates with the drain running.
    for (int i = 0; i < 6; i++)
      applyStimulus(0, 0, 1, 32'h40 + 32'(i) * 4, 1, 32'h40 + 32'(i) * 4, "bp_push");
    for (int i = 0; i < 6; i++) idle(1, 32'h40 + 32'(i) * 4, "bp_check");

    // Aliasing: 0x0 and 0x100 share index 0 and must both land.
    applyStimulus(0, 0, 1, 32'h0, 1, 32'h0, "alias_a");
    applyStimulus(0, 0, 1, 32'h100, 1, 32'h0, "alias_b");
    idle(2, 32'h0, "alias_hit");
    applyStimulus(0, 0, 1, 32'h0, 0, 32'h0, "alias_nt");
    idle(2, 32'h100, "alias_still_t");

    // Clear with updates in flight; a second clear_req mid-sweep is ignored.
    applyStimulus(0, 0, 1, 32'h80, 1, 32'h80, "clr_q1");
    applyStimulus(0, 0, 1, 32'h80, 1, 32'h80, "clr_q2");
    applyStimulus(0, 0, 1, 32'h84, 1, 32'h80, "clr_q3");
    applyStimulus(0, 1, 1, 32'h84, 1, 32'h80, "clr_req");
    for (int i = 0; i < ENTRIES; i++)
      applyStimulus(0, (i == 20), 1, 32'h88, 1, 32'h80, "clr_busy");
    scanAll("post_clear");

    // Reset in the middle of a sweep and in the middle of RUN.
    applyStimulus(0, 1, 0, 32'h0, 0, 32'h0, "rst_pre");
    idle(10, 32'h0, "rst_mid_sweep");
    applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, "rst_sweep");
    idle(ENTRIES + 2, 32'h10, "rst_resweep");
    applyStimulus(0, 0, 1, 32'h30, 1, 32'h30, "rst_run_q");
    applyStimulus(1, 0, 1, 32'h30, 1, 32'h30, "rst_run");
    idle(ENTRIES + 2, 32'h30, "rst_run_sweep");

    // Random traffic over a handful of hot indices with occasional clears and resets.
    for (int i = 0; i < 800; i++) begin
      r    = $urandom;
      pick = $urandom_range(0, 7);
      upc  = ($urandom & 32'hFFFF_FF03) | (32'(pick) << 2);
      lpc  = ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2);
      applyStimulus(($urandom_range(0, 399) == 0), ($urandom_range(0, 149) == 0),
                    r[0] | r[1], upc, r[2], lpc, "random");
    end
    idle(4, 32'h0, "tail");

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
    #3;
    if (expQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
